avg_pool_frame_loader: RTL
==========================

// Module: avg_pool_frame_loader
// PURPOSE
//  Streaming-to-parallel frame assembler directly upstream of avgPoolSingle.
//  Accepts one FP16 feature-map pixel per cycle, in raster order, from the conv/activation stage.
//  Packs pixels into the flat ROWS*COLS*DATA_W vector that drives avgPoolSingle.aPoolIn.
//  Holds the frame stable until the consumer acknowledges it, then reloads.
// PARAMETERS
//  ROWS    28  feature-map rows
//  COLS    28  feature-map columns
//  DATA_W  16  pixel width (IEEE-754 half, passed through untouched)
// PORTS
//  clk         in   1                     rising-edge clock, single domain
//  reset       in   1                     synchronous, active-high
//  pixIn       in   DATA_W                input pixel
//  pixValid    in   1                     pixIn valid
//  pixLast     in   1                     marks last pixel of frame (qualified by pixValid)
//  pixReady    out  1                     loader can accept pixIn this cycle
//  frameOut    out  ROWS*COLS*DATA_W      assembled frame -> avgPoolSingle.aPoolIn
//  frameValid  out  1                     frameOut complete and stable
//  frameAck    in   1                     consumer has sampled frameOut (qualified by frameValid)
//  frameErr    out  1                     one-cycle pulse: malformed frame dropped
//  pixCount    out  clog2(ROWS*COLS+1)    pixels accepted in current frame
// BEHAVIOUR
//  Reset, next clk edge with reset=1:
//   - state=FILL, pixCount=0, frameOut=0, frameValid=0, frameErr=0, pixReady=1.
//   - Reset mid-FILL or mid-HOLD discards the partial or held frame.
//  Transfer: pixel accepted on an edge where pixValid && pixReady.
//  Packing: pixel k (k=row*COLS+col, 0-based) lands at frameOut[(N-1-k)*DATA_W +: DATA_W], N=ROWS*COLS.
//   - Pixel 0 (row0,col0) occupies the MSBs; hex literal reads in raster order.
//  States:
//   - FILL: pixReady=1. Each accept writes its slot and does pixCount++.
//     - Accept with pixCount==N-1 and pixLast=1: go to HOLD, frameValid=1 next cycle, pixCount->0.
//     - Accept with pixLast=1 and pixCount!=N-1 (short frame): frameErr pulse 1 cycle, pixCount->0,
//       stay FILL. Stale slots are not cleared.
//     - Accept with pixCount==N-1 and pixLast=0 (long frame): frameErr pulse, pixCount->0,
//       enter DROP.
//   - DROP: pixReady=1. Accepts and discards pixels until an accepted pixLast, then goes to FILL.
//     frameOut is unchanged.
//   - HOLD: pixReady=0. frameOut frozen, frameValid=1.
//     - frameAck=1 -> FILL next cycle, frameValid=0.
//     - Ack and a new pixel cannot coincide, since pixReady=0 in HOLD.
//     - frameAck while frameValid=0 is ignored.
//  Latency: last pixel accept edge -> frameValid=1 after that same edge (1 cycle).
//  frameOut changes only on FILL-state accepts; it never changes while frameValid=1.
//  pixValid is not required to stay high across bubbles; gaps of any length are legal.
//  No arithmetic on pixel data. pixCount never exceeds N-1 when observed in FILL.
// TESTING
//  T1 reset: drive reset=1 for 2 cycles with pixValid=1 ->
//     frameValid=0, pixCount=0, frameOut=0, pixReady=1.
//  T2 full frame: 784 pixels, alternating 16'h4000/16'h4400 per even row and 16'h4500/16'h4200 per odd row, pixLast on #783 ->
//     frameValid=1 one cycle after; frameOut[12543:12528]=16'h4000; frameOut[15:0]=16'h4200; frameOut[12527:12512]=16'h4400.
//  T3 backpressure: hold frameAck=0 for 50 cycles while pixValid=1 ->
//     pixReady=0 and frameOut unchanged for all 50 cycles.
//     Then frameAck=1 -> frameValid=0, pixReady=1 next cycle.
//  T4 short frame: pixLast on pixel #99 ->
//     frameErr high exactly 1 cycle, pixCount=0, frameValid stays 0.
//     A following good 784-pixel frame completes normally.
//  T5 long frame: 790 pixels with pixLast on #789 ->
//     frameErr at pixel #783, pixels #784..#789 discarded, frameValid never rises.
//     The next frame is assembled correctly.
//  T6 bubbles + mid-frame reset: random pixValid gaps (~30% idle), reset at pixel #400, then a full frame ->
//     output matches a golden raster-packed vector; feeding frameOut to avgPoolSingle gives the expected 14x14 averages.

Source files
------------

// File: rtl/avg_pool_frame_loader.sv
// Raster-order pixel stream to flat frame vector for avgPoolSingle.
// Pixel 0 sits in the MSBs; the frame is held until the consumer acks it.
module avg_pool_frame_loader #(
   parameter  int ROWS   = 28,
   parameter  int COLS   = 28,
   parameter  int DATA_W = 16,
   localparam int N      = ROWS * COLS,
   localparam int CW     = $clog2(N + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_W-1:0]     pixIn,
   input  logic                  pixValid,
   input  logic                  pixLast,
   output logic                  pixReady,
   output logic [N*DATA_W-1:0]   frameOut,
   output logic                  frameValid,
   input  logic                  frameAck,
   output logic                  frameErr,
   output logic [CW-1:0]         pixCount
);

   localparam int BW = $clog2(N * DATA_W);

   typedef enum logic [1:0] {
      FILL,
      DROP,
      HOLD
   } state_t;

   state_t          state_q;
   logic            acc;
   logic            last_slot;
   logic [BW-1:0]   base;

   assign acc       = pixValid && pixReady;
   assign last_slot = (pixCount == CW'(N - 1));
   assign base      = BW'(N - 1 - int'(pixCount)) * BW'(DATA_W);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= FILL;
         pixCount   <= '0;
         frameOut   <= '0;
         frameValid <= 1'b0;
         frameErr   <= 1'b0;
         pixReady   <= 1'b1;
      end else begin
         frameErr <= 1'b0;
         unique case (state_q)
            FILL: begin
               if (acc) begin
                  frameOut[base +: DATA_W] <= pixIn;
                  pixCount <= pixCount + CW'(1);
                  if (pixLast && last_slot) begin
                     state_q    <= HOLD;
                     frameValid <= 1'b1;
                     pixReady   <= 1'b0;
                     pixCount   <= '0;
                  end else if (pixLast) begin
                     frameErr <= 1'b1;
                     pixCount <= '0;
                  end else if (last_slot) begin
                     // overlong frame: flush the remainder up to its pixLast
                     frameErr <= 1'b1;
                     pixCount <= '0;
                     state_q  <= DROP;
                  end
               end
            end
            DROP: begin
               if (acc && pixLast) begin
                  state_q <= FILL;
               end
            end
            HOLD: begin
               if (frameAck) begin
                  state_q    <= FILL;
                  frameValid <= 1'b0;
                  pixReady   <= 1'b1;
               end
            end
            default: begin
               state_q <= FILL;
            end
         endcase
      end
   end

endmodule
